// File: rtl/d5m_pixel_packer.sv
// d5m_pixel_packer: packs the D5M 8-bit pixel stream into 32-bit little-endian
// words, buffers them in a show-ahead FIFO and presents an Avalon-ST source.
// A FIFO overflow terminates the broken packet with an error word and the
// rest of that frame is dropped until the next start-of-frame.
module d5m_pixel_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [1:0]        out_empty,
  output logic              out_error,
  input  logic              clear_status,
  output logic              overflow_sticky,
  output logic              proto_err_sticky,
  output logic [15:0]       frame_count,
  output logic [ADDR_W:0]   fifo_level
);

  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        error;
  } word_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PACK = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Packing context
  logic [31:0] acc;
  logic [1:0]  cnt;
  logic        word_sop;
  logic        sop_emitted;
  logic        term_pending;

  // FIFO storage and bookkeeping
  word_t             mem [0:FIFO_DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LVL_W-1:0]  level;
  word_t             head;

  // Per-cycle decode
  logic        sop_take;
  logic        data_beat;
  logic [1:0]  lane;
  logic        wsop;
  logic        push_data_req;
  logic        term_req;
  logic        proto_set;
  logic        overflow_set;
  logic        pop;
  logic        room;
  logic        push_ok;
  logic [31:0] word_data;
  word_t       push_word;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a rejected eop word ends the frame, any other rejection drops
  // the remainder of the frame; an accepted eop returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (data_beat) begin
      if (push_data_req && !room) begin
        state_nxt = in_eop ? S_IDLE : S_DROP;
      end else if (push_data_req && in_eop) begin
        state_nxt = S_IDLE;
      end else begin
        state_nxt = S_PACK;
      end
    end
  end

  // Beat decode, word assembly and push request generation
  always_comb begin
    sop_take      = 1'b0;
    data_beat     = 1'b0;
    lane          = 2'd0;
    wsop          = 1'b0;
    push_data_req = 1'b0;
    term_req      = 1'b0;
    proto_set     = 1'b0;
    overflow_set  = 1'b0;
    pop           = 1'b0;
    room          = 1'b0;
    push_ok       = 1'b0;
    word_data     = '0;
    push_word     = '0;

    // A pending terminator blocks new frames so it always goes out first
    sop_take      = in_valid && in_sop && !term_pending;
    data_beat     = sop_take || (state == S_PACK && in_valid && !in_sop);
    lane          = sop_take ? 2'd0 : cnt;
    wsop          = sop_take || word_sop;
    push_data_req = data_beat && (lane == 2'd3 || in_eop);
    term_req      = term_pending && !push_data_req;
    proto_set     = (state == S_PACK) && in_valid && in_sop &&
                    (cnt != 2'd0) && !term_pending;

    for (int i = 0; i < 4; i++) begin
      if (2'(i) < lane) begin
        word_data[8*i +: 8] = acc[8*i +: 8];
      end else if (2'(i) == lane) begin
        word_data[8*i +: 8] = in_data;
      end
    end

    if (push_data_req) begin
      push_word.data  = word_data;
      push_word.sop   = wsop;
      push_word.eop   = in_eop;
      push_word.empty = 2'd3 - lane;
      push_word.error = 1'b0;
    end else if (term_req) begin
      push_word.eop   = 1'b1;
      push_word.error = 1'b1;
    end

    pop          = out_valid && out_ready;
    room         = (level != LVL_FULL) || pop;
    push_ok      = (push_data_req || term_req) && room;
    overflow_set = push_data_req && !room;
  end

  // Accumulator, lane counter and frame-tracking flags
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= 2'd0;
      word_sop     <= 1'b0;
      sop_emitted  <= 1'b0;
      term_pending <= 1'b0;
      frame_count  <= 16'd0;
    end else begin
      if (data_beat) begin
        if (push_data_req) begin
          acc      <= '0;
          cnt      <= 2'd0;
          word_sop <= 1'b0;
        end else begin
          acc      <= word_data;
          cnt      <= lane + 2'd1;
          word_sop <= wsop;
        end
      end

      if (push_data_req && room && wsop) begin
        sop_emitted <= 1'b1;
      end else if (sop_take) begin
        sop_emitted <= 1'b0;
      end

      // Only a frame whose sop word reached the sink needs a terminator
      if (overflow_set && !sop_take && sop_emitted) begin
        term_pending <= 1'b1;
      end else if (term_req && room) begin
        term_pending <= 1'b0;
      end

      if (push_data_req && room && in_eop) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Sticky status flags; a set event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_sticky  <= 1'b0;
      proto_err_sticky <= 1'b0;
    end else begin
      overflow_sticky  <= overflow_set | (overflow_sticky  & ~clear_status);
      proto_err_sticky <= proto_set    | (proto_err_sticky & ~clear_status);
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push_ok && !pop) begin
        level <= level + LVL_W'(1);
      end else if (!push_ok && pop) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // Show-ahead head, forced to zero while the FIFO is empty
  assign head       = mem[rd_ptr];
  assign out_valid  = (level != '0);
  assign out_data   = out_valid ? head.data  : 32'd0;
  assign out_sop    = out_valid ? head.sop   : 1'b0;
  assign out_eop    = out_valid ? head.eop   : 1'b0;
  assign out_empty  = out_valid ? head.empty : 2'd0;
  assign out_error  = out_valid ? head.error : 1'b0;
  assign fifo_level = level;

endmodule

// File: tb/tb_d5m_pixel_packer.sv
// tb_d5m_pixel_packer: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based frame model.
module tb_d5m_pixel_packer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_empty;
  logic        out_error;
  logic        clear_status = 1'b0;
  logic        overflow_sticky;
  logic        proto_err_sticky;
  logic [15:0] frame_count;
  logic [AW:0] fifo_level;

  always #5 clk = ~clk;

  d5m_pixel_packer #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_sop           (in_sop),
    .in_eop           (in_eop),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_sop          (out_sop),
    .out_eop          (out_eop),
    .out_empty        (out_empty),
    .out_error        (out_error),
    .clear_status     (clear_status),
    .overflow_sticky  (overflow_sticky),
    .proto_err_sticky (proto_err_sticky),
    .frame_count      (frame_count),
    .fifo_level       (fifo_level)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        err;
  } mword_t;

  mword_t      mq[$];
  logic [7:0]  pend[$];
  bit          m_in_frame = 0;
  bit          m_first    = 0;
  bit          m_emitted  = 0;
  bit          m_term     = 0;
  bit          m_ov       = 0;
  bit          m_pe       = 0;
  logic [15:0] m_fc       = 16'd0;

  task automatic model_edge();
    bit     room;
    bit     pushed;
    bit     ov_set;
    bit     pe_set;
    mword_t w;
    if (rst) begin
      mq.delete(); pend.delete();
      m_in_frame = 0; m_first = 0; m_emitted = 0; m_term = 0;
      m_ov = 0; m_pe = 0; m_fc = 16'd0;
      return;
    end
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    room = (mq.size() < DEPTH);
    pushed = 0; ov_set = 0; pe_set = 0;
    if (in_valid) begin
      if (in_sop && !m_term) begin
        if (m_in_frame && pend.size() > 0) pe_set = 1;
        pend.delete();
        pend.push_back(in_data);
        m_first = 1; m_in_frame = 1; m_emitted = 0;
      end else if (m_in_frame && !in_sop) begin
        pend.push_back(in_data);
      end
      if (m_in_frame && (pend.size() == 4 || in_eop)) begin
        w = '0;
        foreach (pend[i]) w.data = w.data | (32'(pend[i]) << (8 * i));
        w.sop   = m_first;
        w.eop   = in_eop;
        w.empty = 2'(4 - pend.size());
        pushed  = 1;
        if (room) begin
          mq.push_back(w);
          if (m_first) m_emitted = 1;
          if (in_eop) m_fc = m_fc + 16'd1;
        end else begin
          ov_set = 1;
          if (m_emitted) m_term = 1;
          m_in_frame = 0;
        end
        pend.delete();
        m_first = 0;
        if (in_eop) m_in_frame = 0;
      end
    end
    if (!pushed && m_term && room) begin
      w = '0; w.eop = 1; w.err = 1;
      mq.push_back(w);
      m_term = 0;
    end
    m_ov = ov_set | (m_ov & !clear_status);
    m_pe = pe_set | (m_pe & !clear_status);
  endtask

  function automatic logic [63:0] dut_obs();
    return 64'({out_valid, out_data, out_sop, out_eop, out_empty, out_error,
                fifo_level, frame_count, overflow_sticky, proto_err_sticky});
  endfunction

  function automatic logic [63:0] model_obs();
    mword_t h;
    logic   v;
    h = '0;
    v = (mq.size() != 0);
    if (v) h = mq[0];
    return 64'({v, h.data, h.sop, h.eop, h.empty, h.err, 3'(mq.size()),
                m_fc, m_ov, m_pe});
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick_begin();
    @(negedge clk);
    chk("model", dut_obs(), model_obs());
  endtask

  task automatic tick_end();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick_begin();
    tick_end();
  endtask

  task automatic send(input bit v, input logic [7:0] d, input bit s, input bit e);
    in_valid = v; in_data = d; in_sop = s; in_eop = e;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          s;
    bit          e;
    bit          xv;
    logic [31:0] xd;
    bit          xs;
    bit          xe;
    logic [1:0]  xm;
    logic [15:0] xf;
  } vec_t;

  function automatic vec_t mk(bit v, logic [7:0] d, bit s, bit e, bit xv,
                              logic [31:0] xd, bit xs, bit xe, logic [1:0] xm,
                              logic [15:0] xf);
    vec_t r;
    r.v = v; r.d = d; r.s = s; r.e = e;
    r.xv = xv; r.xd = xd; r.xs = xs; r.xe = xe; r.xm = xm; r.xf = xf;
    return r;
  endfunction

  vec_t tbl [19];

  initial begin
    tbl[0]  = mk(1, 8'h01, 1, 0, 0, 32'h0, 0, 0, 2'd0, 16'd0);
    tbl[1]  = mk(1, 8'h02, 0, 0, 0, 32'h0, 0, 0, 2'd0, 16'd0);
    tbl[2]  = mk(1, 8'h03, 0, 0, 0, 32'h0, 0, 0, 2'd0, 16'd0);
    tbl[3]  = mk(1, 8'h04, 0, 0, 0, 32'h0, 0, 0, 2'd0, 16'd0);
    tbl[4]  = mk(1, 8'h05, 0, 0, 1, 32'h04030201, 1, 0, 2'd0, 16'd0);
    tbl[5]  = mk(1, 8'h06, 0, 0, 0, 32'h0, 0, 0, 2'd0, 16'd0);
    tbl[6]  = mk(1, 8'h07, 0, 0, 0, 32'h0, 0, 0, 2'd0, 16'd0);
    tbl[7]  = mk(1, 8'h08, 0, 1, 0, 32'h0, 0, 0, 2'd0, 16'd0);
    tbl[8]  = mk(0, 8'h00, 0, 0, 1, 32'h08070605, 0, 1, 2'd0, 16'd1);
    tbl[9]  = mk(0, 8'h00, 0, 0, 0, 32'h0, 0, 0, 2'd0, 16'd1);
    tbl[10] = mk(1, 8'hA0, 1, 0, 0, 32'h0, 0, 0, 2'd0, 16'd1);
    tbl[11] = mk(1, 8'hA1, 0, 0, 0, 32'h0, 0, 0, 2'd0, 16'd1);
    tbl[12] = mk(1, 8'hA2, 0, 0, 0, 32'h0, 0, 0, 2'd0, 16'd1);
    tbl[13] = mk(1, 8'hA3, 0, 0, 0, 32'h0, 0, 0, 2'd0, 16'd1);
    tbl[14] = mk(1, 8'hA4, 0, 1, 1, 32'hA3A2A1A0, 1, 0, 2'd0, 16'd1);
    tbl[15] = mk(0, 8'h00, 0, 0, 1, 32'h000000A4, 0, 1, 2'd3, 16'd2);
    tbl[16] = mk(1, 8'h55, 1, 1, 0, 32'h0, 0, 0, 2'd0, 16'd2);
    tbl[17] = mk(0, 8'h00, 0, 0, 1, 32'h00000055, 1, 1, 2'd3, 16'd3);
    tbl[18] = mk(0, 8'h00, 0, 0, 0, 32'h0, 0, 0, 2'd0, 16'd3);

    // Initial reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick_begin();
    chk("reset_state", dut_obs(), 64'd0);
    tick_end();

    // Table: 8-byte, 5-byte and 1-byte frames with a free-running sink
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      send(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].e);
      tick_begin();
      chk($sformatf("table_row%0d", i),
          64'({out_valid, out_data, out_sop, out_eop, out_empty, frame_count}),
          64'({tbl[i].xv, tbl[i].xd, tbl[i].xs, tbl[i].xe, tbl[i].xm, tbl[i].xf}));
      tick_end();
    end

    // sop arriving with three bytes pending
    send(1, 8'h11, 1, 0); step();
    send(1, 8'h12, 0, 0); step();
    send(1, 8'h13, 0, 0); step();
    send(1, 8'h21, 1, 0); step();
    send(1, 8'h22, 0, 0);
    tick_begin();
    chk("proto_set", 64'(proto_err_sticky), 64'd1);
    tick_end();
    send(1, 8'h23, 0, 0); step();
    send(1, 8'h24, 0, 0); step();
    send(0, 8'h00, 0, 0);
    tick_begin();
    chk("proto_word", 64'({out_valid, out_data, out_sop, out_eop}),
        64'({1'b1, 32'h24232221, 1'b1, 1'b0}));
    tick_end();
    clear_status = 1'b1; step(); clear_status = 1'b0;
    tick_begin();
    chk("proto_clear", 64'(proto_err_sticky), 64'd0);
    tick_end();

    // Overflow: 6-word frame into a stalled 4-deep FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      send(1, 8'(i), i == 0, i == 23);
      step();
    end
    send(0, 8'h00, 0, 0);
    tick_begin();
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_sticky", 64'(overflow_sticky), 64'd1);
    tick_end();
    out_ready = 1'b1;
    begin
      logic [36:0] exp_w [5];
      exp_w[0] = {32'h03020100, 1'b1, 1'b0, 2'd0, 1'b0};
      exp_w[1] = {32'h07060504, 1'b0, 1'b0, 2'd0, 1'b0};
      exp_w[2] = {32'h0B0A0908, 1'b0, 1'b0, 2'd0, 1'b0};
      exp_w[3] = {32'h0F0E0D0C, 1'b0, 1'b0, 2'd0, 1'b0};
      exp_w[4] = {32'h00000000, 1'b0, 1'b1, 2'd0, 1'b1};
      for (int k = 0; k < 5; k++) begin
        tick_begin();
        chk($sformatf("ovf_drain%0d", k),
            64'({out_valid, out_data, out_sop, out_eop, out_empty, out_error}),
            64'({1'b1, exp_w[k]}));
        tick_end();
      end
    end
    tick_begin();
    chk("ovf_drained", 64'(out_valid), 64'd0);
    tick_end();
    send(1, 8'hC0, 1, 0); step();
    send(1, 8'hC1, 0, 0); step();
    send(1, 8'hC2, 0, 0); step();
    send(1, 8'hC3, 0, 1); step();
    send(0, 8'h00, 0, 0);
    tick_begin();
    chk("ovf_next_frame",
        64'({out_valid, out_data, out_sop, out_eop, out_empty, out_error}),
        64'({1'b1, 32'hC3C2C1C0, 1'b1, 1'b1, 2'd0, 1'b0}));
    tick_end();

    // Full FIFO with simultaneous pop and push
    clear_status = 1'b1; step(); clear_status = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      send(1, 8'(i), i == 0, 0);
      step();
    end
    out_ready = 1'b1;
    send(1, 8'd19, 0, 0); step();
    out_ready = 1'b0;
    send(0, 8'h00, 0, 0);
    tick_begin();
    chk("full_level", 64'(fifo_level), 64'd4);
    chk("full_no_ovf", 64'(overflow_sticky), 64'd0);
    chk("full_head", 64'(out_data), 64'h07060504);
    tick_end();
    out_ready = 1'b1;
    send(1, 8'hEE, 0, 1); step();
    send(0, 8'h00, 0, 0);
    repeat (8) step();

    // Reset in the middle of a frame
    send(1, 8'h31, 1, 0); step();
    send(1, 8'h32, 0, 0); step();
    rst = 1'b1;
    send(1, 8'h33, 0, 0); step();
    rst = 1'b0;
    send(0, 8'h00, 0, 0);
    tick_begin();
    chk("rst_outputs", dut_obs(), 64'd0);
    tick_end();
    for (int i = 0; i < 4; i++) begin
      send(1, 8'(8'h41 + i), 0, i == 3);
      step();
    end
    send(0, 8'h00, 0, 0);
    tick_begin();
    chk("rst_ignore", 64'(out_valid), 64'd0);
    tick_end();
    for (int i = 0; i < 4; i++) begin
      send(1, 8'(8'h51 + i), i == 0, i == 3);
      step();
    end
    send(0, 8'h00, 0, 0);
    tick_begin();
    chk("rst_next_frame",
        64'({out_valid, out_data, out_sop, out_eop, out_empty, out_error}),
        64'({1'b1, 32'h54535251, 1'b1, 1'b1, 2'd0, 1'b0}));
    tick_end();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 499) == 0);
      in_valid     = ($urandom_range(0, 9) < 7);
      in_data      = 8'($urandom);
      in_sop       = ($urandom_range(0, 99) < 8);
      in_eop       = ($urandom_range(0, 99) < 10);
      out_ready    = ($urandom_range(0, 9) < 6);
      clear_status = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0; clear_status = 1'b0; out_ready = 1'b1;
    send(0, 8'h00, 0, 0);
    repeat (10) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
